// File: rtl/mc_config_loader.sv
// Serial configuration loader for the macrocell array: framed bit-serial
// write/readback of one CFG_W-bit mux-select word per macrocell.
module mc_config_loader #(
  parameter int NUM_MC = 16,
  parameter int ADDR_W = 4,
  parameter int CFG_W  = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sdi,
  input  logic                    sdi_valid,
  output logic                    sdi_ready,
  input  logic                    sdi_abort,
  output logic                    sdo,
  output logic                    sdo_valid,
  input  logic                    sdo_ready,
  output logic [NUM_MC*CFG_W-1:0] cfg_flat,
  output logic                    wr_done,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int CW = $clog2(CFG_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_READ} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_op;
  logic [CW-1:0]       r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [CFG_W-1:0]    r_shadow;
  logic [CFG_W-1:0]    r_shift;
  logic [CFG_W-1:0]    r_cfg [NUM_MC];
  logic                r_wr_done;
  logic                r_err;

  logic                w_abort;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_addr_last;
  logic                w_data_last;
  logic                w_rd_last;
  logic                w_rd_addr_ok;
  logic                w_wr_addr_ok;
  logic                w_commit;
  logic                w_set_err;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [CFG_W-1:0]    w_shadow_nxt;
  logic [CFG_W-1:0]    w_rd_word;

  assign sdi_ready = (r_state != S_READ);
  assign sdo_valid = (r_state == S_READ);
  assign sdo       = sdo_valid & r_shift[0];
  assign busy      = (r_state != S_IDLE);
  assign wr_done   = r_wr_done;
  assign err       = r_err;

  // Abort outranks any handshake; in IDLE there is nothing to abort.
  assign w_abort  = sdi_abort && (r_state != S_IDLE);
  assign w_in_hs  = sdi_valid && sdi_ready && !w_abort;
  assign w_out_hs = sdo_valid && sdo_ready && !w_abort;

  assign w_addr_nxt   = ADDR_W'({r_addr, sdi});
  assign w_shadow_nxt = r_shadow | (CFG_W'(sdi) << r_cnt);
  assign w_rd_addr_ok = 32'(w_addr_nxt) < NUM_MC;
  assign w_wr_addr_ok = 32'(r_addr) < NUM_MC;

  assign w_addr_last = (r_state == S_ADDR) && w_in_hs && (r_cnt == CW'(ADDR_W - 1));
  assign w_data_last = (r_state == S_DATA) && w_in_hs && (r_cnt == CW'(CFG_W - 1));
  assign w_rd_last   = (r_state == S_READ) && w_out_hs && (r_cnt == CW'(CFG_W - 1));

  assign w_commit  = w_data_last && w_wr_addr_ok;
  assign w_set_err = (w_data_last && !w_wr_addr_ok) ||
                     (w_addr_last && !r_op && !w_rd_addr_ok);

  always_comb begin
    w_rd_word = '0;
    for (int unsigned k = 0; k < NUM_MC; k++) begin
      if (32'(w_addr_nxt) == k) w_rd_word = r_cfg[k];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_in_hs)     w_state_nxt = S_ADDR;
        S_ADDR:  if (w_addr_last) w_state_nxt = r_op ? S_DATA : S_READ;
        S_DATA:  if (w_data_last) w_state_nxt = S_IDLE;
        S_READ:  if (w_rd_last)   w_state_nxt = S_IDLE;
        default:                  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_shadow  <= '0;
      r_shift   <= '0;
      r_wr_done <= 1'b0;
      r_err     <= 1'b0;
      for (int unsigned k = 0; k < NUM_MC; k++) r_cfg[k] <= '0;
    end else begin
      r_wr_done <= w_commit;

      if (w_set_err)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;

      // The final data bit is folded in via w_shadow_nxt so the commit lands on the same edge.
      if (w_commit) begin
        for (int unsigned k = 0; k < NUM_MC; k++) begin
          if (32'(r_addr) == k) r_cfg[k] <= w_shadow_nxt;
        end
      end

      if (w_abort) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_in_hs) begin
            r_op     <= sdi;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_shadow <= '0;
          end
          S_ADDR: if (w_in_hs) begin
            r_addr <= w_addr_nxt;
            r_cnt  <= w_addr_last ? '0 : r_cnt + 1'b1;
            if (w_addr_last && !r_op) r_shift <= w_rd_word;
          end
          S_DATA: if (w_in_hs) begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= w_data_last ? '0 : r_cnt + 1'b1;
          end
          S_READ: if (w_out_hs) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= w_rd_last ? '0 : r_cnt + 1'b1;
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_MC; g++) begin : g_flat
    assign cfg_flat[g*CFG_W +: CFG_W] = r_cfg[g];
  end

endmodule

// File: tb/tb_mc_config_loader.sv
// Randomized self-checking bench for mc_config_loader against an array-based
// model of the stored words and the sticky error flag.
module tb_mc_config_loader;

  localparam int NUM_MC = 12;
  localparam int ADDR_W = 4;
  localparam int CFG_W  = 19;
  localparam int FW     = NUM_MC * CFG_W;

  logic          clk = 1'b0;
  logic          rst_n, sdi, sdi_valid, sdi_abort, sdo_ready, err_clr;
  logic          sdi_ready, sdo, sdo_valid, wr_done, busy, err;
  logic [FW-1:0] cfg_flat;

  mc_config_loader #(.NUM_MC(NUM_MC), .ADDR_W(ADDR_W), .CFG_W(CFG_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
    .sdi_abort(sdi_abort), .sdo(sdo), .sdo_valid(sdo_valid), .sdo_ready(sdo_ready),
    .cfg_flat(cfg_flat), .wr_done(wr_done), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  logic [CFG_W-1:0]  m_cfg [NUM_MC];
  logic              m_err;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] m_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_MC; k++) f[k*CFG_W +: CFG_W] = m_cfg[k];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gapwait(input int gap);
    repeat (gap) step();
  endtask

  task automatic send_bit(input logic b);
    chk("sdi_ready", sdi_ready, 1);
    sdi       = b;
    sdi_valid = 1'b1;
    step();
    sdi_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic op, input logic [ADDR_W-1:0] addr, input int gap);
    send_bit(op);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      gapwait(gap);
      send_bit(addr[i]);
    end
  endtask

  task automatic write_frame(input logic [ADDR_W-1:0] addr, input logic [CFG_W-1:0] data,
                             input int gap, input bit b2b, input bit clr_last);
    bit in_rng;
    in_rng = 32'(addr) < NUM_MC;
    send_hdr(1'b1, addr, gap);
    for (int i = 0; i < CFG_W; i++) begin
      gapwait(gap);
      if (i == CFG_W - 1 && clr_last) err_clr = 1'b1;
      send_bit(data[i]);
      err_clr = 1'b0;
    end
    if (in_rng) begin
      m_cfg[addr] = data;
      if (clr_last) m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    chk("wr_done_pulse", wr_done, in_rng);
    chk("wr_cfg", cfg_flat, m_flat());
    chk("wr_err", err, m_err);
    chk("wr_busy", busy, 0);
    if (!b2b) begin
      step();
      chk("wr_done_end", wr_done, 0);
    end
  endtask

  task automatic read_frame(input logic [ADDR_W-1:0] addr, input int gap, input bit toggle);
    logic [CFG_W-1:0] exp, got;
    logic             prev;
    bit               held;
    int               n, cyc;
    exp  = (32'(addr) < NUM_MC) ? m_cfg[addr] : '0;
    if (!(32'(addr) < NUM_MC)) m_err = 1'b1;
    got  = '0;
    n    = 0;
    cyc  = 0;
    held = 0;
    prev = 1'b0;
    send_hdr(1'b0, addr, gap);
    chk("rd_err", err, m_err);
    while (n < CFG_W && cyc < 200) begin
      sdo_ready = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      chk("rd_sdo_valid", sdo_valid, 1);
      chk("rd_sdi_ready", sdi_ready, 0);
      if (held) chk("rd_sdo_hold", sdo, prev);
      if (sdo_ready) begin
        got[n] = sdo;
        n++;
        held = 0;
      end else begin
        held = 1;
        prev = sdo;
      end
      step();
      cyc++;
    end
    sdo_ready = 1'b0;
    if (n < CFG_W) chk("rd_timeout", n, CFG_W);
    chk("rd_word", got, exp);
    chk("rd_sdo_valid_end", sdo_valid, 0);
    chk("rd_busy_end", busy, 0);
  endtask

  initial begin
    logic [CFG_W-1:0] word_before;
    rst_n = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; sdi_abort = 1'b0;
    sdo_ready = 1'b0; err_clr = 1'b0;
    for (int k = 0; k < NUM_MC; k++) m_cfg[k] = '0;
    m_err = 1'b0;
    step(); step();
    rst_n = 1'b1;

    chk("rst_cfg", cfg_flat, 0);
    chk("rst_sdi_ready", sdi_ready, 1);
    chk("rst_sdo_valid", sdo_valid, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_done", wr_done, 0);

    write_frame(4'd3, 19'h5A5A5, 0, 0, 0);
    read_frame(4'd3, 0, 1);

    write_frame(4'd13, 19'h7FFFF, 0, 0, 0);
    read_frame(4'd14, 0, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0; m_err = 1'b0;
    chk("err_clr", err, 0);
    write_frame(4'd13, 19'h12345, 0, 0, 1);
    chk("err_set_wins", err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0; m_err = 1'b0;
    chk("err_clr2", err, 0);

    // Abort part-way through data.
    send_hdr(1'b1, 4'd5, 0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
    sdi_abort = 1'b1; step(); sdi_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cfg", cfg_flat, m_flat());
    write_frame(4'd5, 19'h00001, 0, 0, 0);

    // Abort coinciding with the final data bit.
    send_hdr(1'b1, 4'd5, 0);
    for (int i = 0; i < CFG_W - 1; i++) send_bit(1'b1);
    sdi = 1'b1; sdi_valid = 1'b1; sdi_abort = 1'b1;
    step();
    sdi_valid = 1'b0; sdi_abort = 1'b0;
    chk("abort_last_wr_done", wr_done, 0);
    chk("abort_last_busy", busy, 0);
    chk("abort_last_cfg", cfg_flat, m_flat());

    // Abort during readback.
    send_hdr(1'b0, 4'd3, 0);
    sdo_ready = 1'b1; step(); step(); step();
    sdo_ready = 1'b0; sdi_abort = 1'b1; step(); sdi_abort = 1'b0;
    chk("abort_rd_sdo_valid", sdo_valid, 0);
    chk("abort_rd_busy", busy, 0);

    write_frame(4'd0, 19'h40000, 2, 1, 0);
    write_frame(4'd1, 19'h0BEEF, 0, 0, 0);
    read_frame(4'd0, 1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        write_frame(a, CFG_W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
      else
        read_frame(a, $urandom_range(0, 1), 0);
      if (m_err && $urandom_range(0, 3) == 0) begin
        err_clr = 1'b1; step(); err_clr = 1'b0; m_err = 1'b0;
        chk("rand_err_clr", err, 0);
      end
    end

    // Reset mid-DATA discards the frame and clears every word.
    write_frame(4'd7, 19'h2AAAA, 0, 0, 0);
    word_before = m_cfg[7];
    chk("pre_rst_word7", cfg_flat[7*CFG_W +: CFG_W], word_before);
    send_hdr(1'b1, 4'd7, 0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int k = 0; k < NUM_MC; k++) m_cfg[k] = '0;
    m_err = 1'b0;
    chk("midrst_cfg", cfg_flat, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sdi_ready", sdi_ready, 1);
    chk("midrst_wr_done", wr_done, 0);
    chk("midrst_err", err, 0);
    write_frame(4'd7, 19'h13579, 0, 0, 0);
    read_frame(4'd7, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
